cn_msg_gen: RTL

- Check-node message generator; sits directly downstream of the 20-input min-sum tree.
- Captures one check-node result per handshake: min1, min2, min1_index, the per-edge input signs and the active degree.
- Emits the check-to-variable messages serially, one edge per beat, on a valid/ready stream.
- Applies the offset-min-sum correction with saturation at zero.

---
 rtl/ldpc_cn_pkg.sv | 14 +
 rtl/offset_sat.sv | 16 +
 rtl/cn_msg_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ldpc_cn_pkg.sv
// Shared LDPC check-node constants and message type, common to the min-sum tree,
// the check-node message generator and the variable-node stage.
package ldpc_cn_pkg;

    localparam int DEG_MAX = 20;
    localparam int IDX_W   = 5;
    localparam int MAG_W   = 5;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } msg_t;

endpackage

// File: rtl/offset_sat.sv
// Offset-min-sum correction: subtracts OFFSET from a magnitude, clamping at zero.
module offset_sat
    import ldpc_cn_pkg::*;
#(
    parameter int OFFSET = 1
) (
    input  logic [MAG_W-1:0] sel,
    output logic [MAG_W-1:0] mag
);

    localparam logic [MAG_W-1:0] OFF = MAG_W'(OFFSET);

    // Anything at or below the offset collapses to zero rather than wrapping.
    assign mag = (sel > OFF) ? (sel - OFF) : '0;

endmodule

// File: rtl/cn_msg_gen.sv
// Check-node message generator: captures one min-sum result and streams the
// offset-corrected check-to-variable messages, one edge per beat.
module cn_msg_gen
    import ldpc_cn_pkg::*;
#(
    parameter int OFFSET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W-1:0]   min1,
    input  logic [MAG_W-1:0]   min2,
    input  logic [IDX_W-1:0]   min1_index,
    input  logic [DEG_MAX-1:0] signs,
    input  logic [IDX_W-1:0]   deg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAG_W:0]     out_msg,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_last
);

    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a valid beat holds its payload until taken.

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [MAG_W-1:0]   min1_q, min1_d;
    logic [MAG_W-1:0]   min2_q, min2_d;
    logic [IDX_W-1:0]   min1_index_q, min1_index_d;
    logic [DEG_MAX-1:0] signs_q, signs_d;
    logic [IDX_W-1:0]   deg_eff_q, deg_eff_d;
    logic               total_sign_q, total_sign_d;

    logic               out_valid_q, out_valid_d;
    msg_t               out_msg_q, out_msg_d;
    logic [IDX_W-1:0]   out_index_q, out_index_d;
    logic               out_last_q, out_last_d;

    logic [IDX_W-1:0]   deg_eff_in;
    logic               total_sign_in;
    logic               capture;
    logic               beat_taken;
    logic [MAG_W-1:0]   sel_d;
    logic [MAG_W-1:0]   mag_d;

    assign beat_taken = out_valid_q && out_ready;
    assign in_ready   = !rst && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_EMIT) && beat_taken && out_last_q));
    assign capture    = in_valid && in_ready;

    // Out-of-range degrees (0 or above DEG_MAX) fall back to a full-degree node.
    always_comb begin
        deg_eff_in    = deg;
        if ((deg == '0) || (deg > IDX_W'(DEG_MAX))) begin
            deg_eff_in = IDX_W'(DEG_MAX);
        end
        total_sign_in = 1'b0;
        for (int i = 0; i < DEG_MAX; i++) begin
            if (IDX_W'(i) < deg_eff_in) begin
                total_sign_in = total_sign_in ^ signs[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        min1_d       = min1_q;
        min2_d       = min2_q;
        min1_index_d = min1_index_q;
        signs_d      = signs_q;
        deg_eff_d    = deg_eff_q;
        total_sign_d = total_sign_q;
        out_valid_d  = out_valid_q;
        if (capture) begin
            state_d      = ST_EMIT;
            cnt_d        = '0;
            min1_d       = min1;
            min2_d       = min2;
            min1_index_d = min1_index;
            signs_d      = signs;
            deg_eff_d    = deg_eff_in;
            total_sign_d = total_sign_in;
            out_valid_d  = 1'b1;
        end else if ((state_q == ST_EMIT) && beat_taken) begin
            if (out_last_q) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    // The beat for the upcoming edge is built from next-state values so it is
    // registered in the same edge that advances the counter or captures a result.
    assign sel_d = (cnt_d == min1_index_d) ? min2_d : min1_d;

    offset_sat #(
        .OFFSET (OFFSET)
    ) u_offset_sat (
        .sel (sel_d),
        .mag (mag_d)
    );

    always_comb begin
        out_msg_d   = out_msg_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        if (out_valid_d) begin
            out_msg_d.sign = total_sign_d ^ signs_d[cnt_d];
            out_msg_d.mag  = mag_d;
            out_index_d    = cnt_d;
            out_last_d     = (cnt_d == (deg_eff_d - IDX_W'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            min1_q       <= '0;
            min2_q       <= '0;
            min1_index_q <= '0;
            signs_q      <= '0;
            deg_eff_q    <= '0;
            total_sign_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_msg_q    <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            min1_q       <= min1_d;
            min2_q       <= min2_d;
            min1_index_q <= min1_index_d;
            signs_q      <= signs_d;
            deg_eff_q    <= deg_eff_d;
            total_sign_q <= total_sign_d;
            out_valid_q  <= out_valid_d;
            out_msg_q    <= out_msg_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule
